// File: rtl/any1_pkg.sv
// Shared reorder-buffer types and the age-ordering helper used by the
// allocator and by anything else that has to compare two ROB ids.
package any1_pkg;

  localparam int ROB_ENTRIES = 64;

  typedef logic [5:0] RobPtr;
  typedef logic [6:0] RobCnt;

  // True when entry a was allocated after entry b; ages are distances from head.
  function automatic logic is_younger(input RobPtr a, input RobPtr b, input RobPtr head,
                                      input RobPtr mask = RobPtr'(ROB_ENTRIES - 1));
    RobPtr age_a;
    RobPtr age_b;
    age_a = (a - head) & mask;
    age_b = (b - head) & mask;
    return age_a > age_b;
  endfunction

endpackage

// File: rtl/any1_rob_alloc_if.sv
// Decode / execute / retire / flush handshake bundle for the ROB allocator.
// The slave side is the ROB itself.
interface any1_rob_alloc_if;
  import any1_pkg::*;

  logic  alloc_req_i;
  logic  alloc_gnt_o;
  RobPtr alloc_rid_o;
  logic  done_i;
  RobPtr done_rid_i;
  logic  cmt_stall_i;
  logic  cmt_o;
  RobPtr cmt_rid_o;
  logic  flush_i;
  RobPtr flush_rid_i;
  RobCnt count_o;
  logic  full_o;
  logic  empty_o;

  modport slave (
    input  alloc_req_i, done_i, done_rid_i, cmt_stall_i, flush_i, flush_rid_i,
    output alloc_gnt_o, alloc_rid_o, cmt_o, cmt_rid_o, count_o, full_o, empty_o
  );

  modport master (
    output alloc_req_i, done_i, done_rid_i, cmt_stall_i, flush_i, flush_rid_i,
    input  alloc_gnt_o, alloc_rid_o, cmt_o, cmt_rid_o, count_o, full_o, empty_o
  );

endinterface

// File: rtl/any1_rob_alloc.sv
// Reorder-buffer id allocator: in-order allocate at tail, out-of-order done,
// in-order commit at head, and branch-mispredict flush of younger entries.
module any1_rob_alloc #(
  parameter int ROB_ENTRIES = 64
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  any1_rob_alloc_if.slave  rob
);
  import any1_pkg::*;

  localparam RobPtr PTR_MASK = RobPtr'(ROB_ENTRIES - 1);
  localparam RobCnt FULL_CNT = RobCnt'(ROB_ENTRIES);

  RobPtr head_q, head_d;
  RobPtr tail_q, tail_d;
  RobCnt count_q, count_d;
  logic [ROB_ENTRIES-1:0] valid_q, valid_d;
  logic [ROB_ENTRIES-1:0] done_q, done_d;

  logic  full;
  logic  empty;
  logic  gnt;
  logic  cmt;
  logic  flush_act;
  RobPtr flush_age;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Grant looks at the registered count, so a commit never frees a slot same-cycle.
  assign gnt = rob.alloc_req_i & ~full & ~rob.flush_i & rst_ni;
  assign cmt = ~empty & done_q[rob.cmt_rid_o] & ~rob.cmt_stall_i;

  assign flush_act = rob.flush_i & valid_q[rob.flush_rid_i];
  assign flush_age = (rob.flush_rid_i - head_q) & PTR_MASK;

  assign rob.alloc_gnt_o = gnt;
  assign rob.alloc_rid_o = tail_q;
  assign rob.cmt_o       = cmt;
  assign rob.cmt_rid_o   = head_q;
  assign rob.count_o     = count_q;
  assign rob.full_o      = full;
  assign rob.empty_o     = empty;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + RobCnt'(gnt) - RobCnt'(cmt);

    if (cmt) begin
      head_d = (head_q + RobPtr'(1)) & PTR_MASK;
    end
    if (gnt) begin
      tail_d = (tail_q + RobPtr'(1)) & PTR_MASK;
    end
    // Entries kept are head..flush_rid inclusive, less one if head retires now.
    if (flush_act) begin
      tail_d  = (rob.flush_rid_i + RobPtr'(1)) & PTR_MASK;
      count_d = RobCnt'(flush_age) + RobCnt'(1) - RobCnt'(cmt);
    end
  end

  always_comb begin
    valid_d = valid_q;
    done_d  = done_q;
    for (int i = 0; i < ROB_ENTRIES; i++) begin
      if (rob.done_i && valid_q[i] && (rob.done_rid_i == RobPtr'(i))) begin
        done_d[i] = 1'b1;
      end
      if (cmt && (head_q == RobPtr'(i))) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
      if (gnt && (tail_q == RobPtr'(i))) begin
        valid_d[i] = 1'b1;
        done_d[i]  = 1'b0;
      end
      // Applied last so a same-cycle done to a discarded entry is dropped.
      if (flush_act && is_younger(RobPtr'(i), rob.flush_rid_i, head_q, PTR_MASK)) begin
        valid_d[i] = 1'b0;
        done_d[i]  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_any1_rob_alloc.sv
// Directed bench for the ROB allocator: fill/full, in-order commit, flush,
// wrapped flush, flush-while-committing, stray done and async reset.
module tb_any1_rob_alloc;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  any1_rob_alloc_if rob_if ();

  any1_rob_alloc #(
    .ROB_ENTRIES(64)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .rob    (rob_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    clk                = 1'b0;
    rst_n              = 1'b0;
    checks             = 0;
    failures           = 0;
    rob_if.alloc_req_i = 1'b1;
    rob_if.done_i      = 1'b0;
    rob_if.done_rid_i  = '0;
    rob_if.cmt_stall_i = 1'b0;
    rob_if.flush_i     = 1'b0;
    rob_if.flush_rid_i = '0;

    // Reset held with a pending request
    repeat (2) @(negedge clk);
    #1;
    chk("rst_gnt",   rob_if.alloc_gnt_o, 0);
    chk("rst_arid",  rob_if.alloc_rid_o, 0);
    chk("rst_cmt",   rob_if.cmt_o,       0);
    chk("rst_crid",  rob_if.cmt_rid_o,   0);
    chk("rst_count", rob_if.count_o,     0);
    chk("rst_full",  rob_if.full_o,      0);
    chk("rst_empty", rob_if.empty_o,     1);
    $display("step reset: outputs checked");

    // Fill: 64 grants, rids 0..63, then full
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 64; i++) begin
      #1;
      chk("fill_gnt", rob_if.alloc_gnt_o, 1);
      chk("fill_rid", rob_if.alloc_rid_o, i);
      @(negedge clk);
    end
    #1;
    chk("full_flag",  rob_if.full_o,      1);
    chk("full_gnt65", rob_if.alloc_gnt_o, 0);
    chk("full_count", rob_if.count_o,     64);
    $display("step fill: 64 rids allocated");

    // Full with head done: commit and request together, no same-cycle reuse
    rob_if.alloc_req_i = 1'b0;
    rob_if.done_i      = 1'b1;
    rob_if.done_rid_i  = 6'd0;
    @(negedge clk);
    rob_if.done_i      = 1'b0;
    rob_if.alloc_req_i = 1'b1;
    #1;
    chk("fullcmt_cmt",  rob_if.cmt_o,       1);
    chk("fullcmt_crid", rob_if.cmt_rid_o,   0);
    chk("fullcmt_gnt",  rob_if.alloc_gnt_o, 0);
    @(negedge clk);
    #1;
    chk("fullcmt_count", rob_if.count_o,     63);
    chk("fullcmt_full",  rob_if.full_o,      0);
    chk("fullcmt_gnt2",  rob_if.alloc_gnt_o, 1);
    chk("fullcmt_arid",  rob_if.alloc_rid_o, 0);
    rob_if.alloc_req_i = 1'b0;
    $display("step full commit: head 0 retired");

    // Asynchronous reset pulse mid-stream
    @(negedge clk);
    rob_if.alloc_req_i = 1'b1;
    rst_n              = 1'b0;
    #1;
    chk("arst_empty", rob_if.empty_o,     1);
    chk("arst_count", rob_if.count_o,     0);
    chk("arst_gnt",   rob_if.alloc_gnt_o, 0);
    chk("arst_crid",  rob_if.cmt_rid_o,   0);
    chk("arst_arid",  rob_if.alloc_rid_o, 0);
    @(negedge clk);
    rst_n              = 1'b1;
    rob_if.alloc_req_i = 1'b0;
    rob_if.done_i      = 1'b1;
    rob_if.done_rid_i  = 6'd20;
    @(negedge clk);
    rob_if.done_i = 1'b0;
    #1;
    chk("stray_cmt",   rob_if.cmt_o,   0);
    chk("stray_empty", rob_if.empty_o, 1);
    chk("stray_count", rob_if.count_o, 0);
    $display("step reset pulse + stray done");

    // Out-of-order done, in-order commit
    rob_if.alloc_req_i = 1'b1;
    repeat (4) @(negedge clk);
    rob_if.alloc_req_i = 1'b0;
    #1;
    chk("ooo_count", rob_if.count_o,     4);
    chk("ooo_arid",  rob_if.alloc_rid_o, 4);
    rob_if.done_i     = 1'b1;
    rob_if.done_rid_i = 6'd2;
    @(negedge clk);
    rob_if.done_rid_i = 6'd0;
    #1;
    chk("ooo_cmt_none", rob_if.cmt_o, 0);
    @(negedge clk);
    rob_if.done_i = 1'b0;
    #1;
    chk("ooo_cmt0",  rob_if.cmt_o,     1);
    chk("ooo_crid0", rob_if.cmt_rid_o, 0);
    @(negedge clk);
    #1;
    chk("ooo_wait1", rob_if.cmt_o,     0);
    chk("ooo_crid1", rob_if.cmt_rid_o, 1);
    rob_if.done_i     = 1'b1;
    rob_if.done_rid_i = 6'd1;
    @(negedge clk);
    rob_if.done_i      = 1'b0;
    rob_if.cmt_stall_i = 1'b1;
    #1;
    chk("ooo_stall", rob_if.cmt_o, 0);
    @(negedge clk);
    rob_if.cmt_stall_i = 1'b0;
    #1;
    chk("ooo_cmt1",    rob_if.cmt_o,     1);
    chk("ooo_crid1b",  rob_if.cmt_rid_o, 1);
    @(negedge clk);
    #1;
    chk("ooo_cmt2",  rob_if.cmt_o,     1);
    chk("ooo_crid2", rob_if.cmt_rid_o, 2);
    @(negedge clk);
    #1;
    chk("ooo_cmt3",   rob_if.cmt_o,     0);
    chk("ooo_crid3",  rob_if.cmt_rid_o, 3);
    chk("ooo_count1", rob_if.count_o,   1);
    $display("step out-of-order done: commits 0,1,2");

    // Flush: invalid target ignored, then flush at rid 4 with 0..9 live
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n              = 1'b1;
    rob_if.alloc_req_i = 1'b1;
    repeat (10) @(negedge clk);
    rob_if.flush_i     = 1'b1;
    rob_if.flush_rid_i = 6'd20;
    #1;
    chk("flinv_gnt", rob_if.alloc_gnt_o, 0);
    @(negedge clk);
    rob_if.flush_i = 1'b0;
    #1;
    chk("flinv_count", rob_if.count_o,     10);
    chk("flinv_arid",  rob_if.alloc_rid_o, 10);
    chk("flinv_gnt2",  rob_if.alloc_gnt_o, 1);
    rob_if.flush_i     = 1'b1;
    rob_if.flush_rid_i = 6'd4;
    rob_if.done_i      = 1'b1;
    rob_if.done_rid_i  = 6'd7;
    #1;
    chk("fl4_gnt", rob_if.alloc_gnt_o, 0);
    @(negedge clk);
    rob_if.flush_i = 1'b0;
    rob_if.done_i  = 1'b0;
    #1;
    chk("fl4_count", rob_if.count_o,     5);
    chk("fl4_arid",  rob_if.alloc_rid_o, 5);
    chk("fl4_gnt",   rob_if.alloc_gnt_o, 1);
    chk("fl4_crid",  rob_if.cmt_rid_o,   0);
    @(negedge clk);
    rob_if.alloc_req_i = 1'b0;
    #1;
    chk("fl4_count6", rob_if.count_o,     6);
    chk("fl4_arid6",  rob_if.alloc_rid_o, 6);
    $display("step flush rid 4: tail back to 5");

    // Wrapped flush: head 60, tail 4, flush at 62
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n              = 1'b1;
    rob_if.alloc_req_i = 1'b1;
    repeat (60) @(negedge clk);
    rob_if.alloc_req_i = 1'b0;
    for (int i = 0; i < 60; i++) begin
      rob_if.done_i     = 1'b1;
      rob_if.done_rid_i = 6'(i);
      @(negedge clk);
    end
    rob_if.done_i = 1'b0;
    @(negedge clk);
    #1;
    chk("wrap_drained", rob_if.count_o,   0);
    chk("wrap_head60",  rob_if.cmt_rid_o, 60);
    chk("wrap_empty",   rob_if.empty_o,   1);
    rob_if.alloc_req_i = 1'b1;
    repeat (8) @(negedge clk);
    rob_if.alloc_req_i = 1'b0;
    #1;
    chk("wrap_count8", rob_if.count_o,     8);
    chk("wrap_tail4",  rob_if.alloc_rid_o, 4);
    rob_if.flush_i     = 1'b1;
    rob_if.flush_rid_i = 6'd62;
    @(negedge clk);
    rob_if.flush_i = 1'b0;
    #1;
    chk("wrapfl_count", rob_if.count_o,     3);
    chk("wrapfl_tail",  rob_if.alloc_rid_o, 63);
    chk("wrapfl_head",  rob_if.cmt_rid_o,   60);
    $display("step wrapped flush at 62");

    // Flush of the head while it commits leaves the ROB empty
    rob_if.done_i     = 1'b1;
    rob_if.done_rid_i = 6'd60;
    @(negedge clk);
    rob_if.done_i      = 1'b0;
    rob_if.flush_i     = 1'b1;
    rob_if.flush_rid_i = 6'd60;
    #1;
    chk("hdfl_cmt", rob_if.cmt_o, 1);
    @(negedge clk);
    rob_if.flush_i = 1'b0;
    #1;
    chk("hdfl_count", rob_if.count_o,     0);
    chk("hdfl_empty", rob_if.empty_o,     1);
    chk("hdfl_tail",  rob_if.alloc_rid_o, 61);
    chk("hdfl_head",  rob_if.cmt_rid_o,   61);
    $display("step flush head while committing");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
